// File: rtl/dac_out_pkg.sv
// Shared defaults, serializer state encoding and a width helper for the DAC lane serializer.
package dac_out_pkg;

    localparam int DEF_NUM_CH = 8;
    localparam int DEF_LANES  = 4;
    localparam int DEF_DW     = 10;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dac_lane_fifo.sv
// Per-channel word FIFO: block-RAM array with a registered read port that
// prefetches the head word, so a pop can consume rd_data in the same cycle.
module dac_lane_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             avail,
    output logic             full,
    output logic             nonempty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW:0]      count;
    logic [AW-1:0]    rd_addr;
    logic             avail_reg;

    assign count    = wr_ptr_reg - rd_ptr_reg;
    // count never exceeds DEPTH, so its top bit alone marks full
    assign full     = count[AW];
    assign nonempty = (count != '0);
    assign rd_addr  = rd_ptr_reg[AW-1:0] + AW'(rd_en);
    assign rd_data  = rd_data_reg;
    assign avail    = avail_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            avail_reg  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            // Head is valid only if it was written before this edge's read.
            avail_reg <= ((count - (AW+1)'(rd_en)) != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        rd_data_reg <= mem[rd_addr];
    end

endmodule

// File: rtl/dac_lane_serializer.sv
// Buffers multi-lane sample words per channel and serializes them one lane per
// accepted beat, arbitrating channels round-robin without bubbles between words.
module dac_lane_serializer
    import dac_out_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int LANES  = DEF_LANES,
    parameter int DW     = DEF_DW,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                          clk_250MHz,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             in_en,
    input  logic [NUM_CH-1:0]             in_last,
    input  logic [NUM_CH*LANES*DW-1:0]    in_dat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DW-1:0]                 out_dat,
    output logic [ch_bits(NUM_CH)-1:0]    out_ch,
    output logic                          out_last,
    output logic [NUM_CH-1:0]             ovf,
    input  logic                          ovf_clr,
    output logic                          busy
);
    localparam int CHW = ch_bits(NUM_CH);
    localparam int WW  = LANES * DW;
    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;

    logic [NUM_CH-1:0] avail;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] nonempty;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] ovf_set;
    logic [WW:0]       rd_word [NUM_CH];

    state_t            state_reg, state_next;
    logic [WW-1:0]     shift_reg, shift_next;
    logic              tag_reg, tag_next;
    logic [LW-1:0]     idx_reg, idx_next;
    logic [CHW-1:0]    ch_reg, ch_next;
    logic [CHW-1:0]    rr_reg, rr_next;
    logic [NUM_CH-1:0] ovf_reg;

    logic              win_found;
    logic [CHW-1:0]    win_ch;
    logic [CHW-1:0]    cand;
    logic              load;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // A full FIFO still takes the word when it frees a slot this cycle.
            assign push[gi]    = in_en[gi] && (!full[gi] || pop[gi]);
            assign ovf_set[gi] = in_en[gi] && full[gi] && !pop[gi];

            dac_lane_fifo #(
                .WIDTH (WW + 1),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk      (clk_250MHz),
                .rst_n    (rst_n),
                .wr_en    (push[gi]),
                .wr_data  ({in_last[gi], in_dat[gi*WW +: WW]}),
                .rd_en    (pop[gi]),
                .rd_data  (rd_word[gi]),
                .avail    (avail[gi]),
                .full     (full[gi]),
                .nonempty (nonempty[gi])
            );
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = CHW'((int'(rr_reg) + 1 + i) % NUM_CH);
            if (!win_found && avail[cand]) begin
                win_found = 1'b1;
                win_ch    = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        tag_next   = tag_reg;
        idx_next   = idx_reg;
        ch_next    = ch_reg;
        rr_next    = rr_reg;
        pop        = '0;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (win_found) load = 1'b1;
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_reg == LW'(LANES - 1)) begin
                        if (win_found) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                            shift_next = '0;
                            tag_next   = 1'b0;
                            idx_next   = '0;
                        end
                    end else begin
                        shift_next = shift_reg >> DW;
                        idx_next   = idx_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            pop[win_ch] = 1'b1;
            shift_next  = rd_word[win_ch][WW-1:0];
            tag_next    = rd_word[win_ch][WW];
            idx_next    = '0;
            ch_next     = win_ch;
            rr_next     = win_ch;
            state_next  = SEND;
        end
    end

    always_ff @(posedge clk_250MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            tag_reg   <= 1'b0;
            idx_reg   <= '0;
            ch_reg    <= '0;
            rr_reg    <= CHW'(NUM_CH - 1);
            ovf_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            tag_reg   <= tag_next;
            idx_reg   <= idx_next;
            ch_reg    <= ch_next;
            rr_reg    <= rr_next;
            // A new overflow outranks a simultaneous clear.
            ovf_reg   <= (ovf_reg & ~{NUM_CH{ovf_clr}}) | ovf_set;
        end
    end

    assign out_valid = (state_reg == SEND);
    assign out_dat   = shift_reg[DW-1:0];
    assign out_ch    = ch_reg;
    assign out_last  = (state_reg == SEND) && tag_reg && (idx_reg == LW'(LANES - 1));
    assign ovf       = ovf_reg;
    assign busy      = (|nonempty) || (state_reg != IDLE);

endmodule

// File: tb/tb_dac_lane_serializer.sv
// Scoreboard bench: default-parameter instance for directed scenarios plus a
// 2-channel single-lane instance driven by a random push/ready stream.
module tb_dac_lane_serializer;

    typedef struct {
        int ch;
        int dat;
        bit last;
    } sample_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   in_en = '0;
    logic [7:0]   in_last = '0;
    logic [319:0] in_dat = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [9:0]   out_dat;
    logic [2:0]   out_ch;
    logic         out_last;
    logic [7:0]   ovf;
    logic         ovf_clr = 1'b0;
    logic         busy;

    logic [1:0]   s_in_en = '0;
    logic [1:0]   s_in_last = '0;
    logic [31:0]  s_in_dat = '0;
    logic         s_valid;
    logic         s_ready = 1'b0;
    logic [15:0]  s_dat;
    logic [0:0]   s_ch;
    logic         s_last;
    logic [1:0]   s_ovf;
    logic         s_busy;

    int checks = 0;
    int passed = 0;
    sample_t exp_q[$];
    logic [15:0] sq [2][$];

    always #2 clk = ~clk;

    dac_lane_serializer dut (
        .clk_250MHz (clk),
        .rst_n      (rst_n),
        .in_en      (in_en),
        .in_last    (in_last),
        .in_dat     (in_dat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dat    (out_dat),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .busy       (busy)
    );

    dac_lane_serializer #(.NUM_CH(2), .LANES(1), .DW(16), .DEPTH(2)) u_small (
        .clk_250MHz (clk),
        .rst_n      (rst_n),
        .in_en      (s_in_en),
        .in_last    (s_in_last),
        .in_dat     (s_in_dat),
        .out_valid  (s_valid),
        .out_ready  (s_ready),
        .out_dat    (s_dat),
        .out_ch     (s_ch),
        .out_last   (s_last),
        .ovf        (s_ovf),
        .ovf_clr    (1'b0),
        .busy       (s_busy)
    );

    task automatic stage_word(input int c, input int base, input bit last, input bit record);
        in_en[c]   = 1'b1;
        in_last[c] = last;
        for (int l = 0; l < 4; l++) begin
            in_dat[(c*4+l)*10 +: 10] = 10'(base + l);
            if (record) exp_q.push_back('{ch: c, dat: base + l, last: (last && l == 3)});
        end
    endtask

    task automatic step_push();
        @(negedge clk);
        in_en   = '0;
        in_last = '0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) $display("FAIL %s wait_valid: out_valid=%b required 1 within 10 cycles", tag, out_valid);
        else passed++;
    endtask

    task automatic drain(input int budget, input bit no_bubble, input string tag);
        int cyc;
        bit started;
        sample_t e;
        cyc = 0;
        started = 1'b0;
        while (exp_q.size() > 0 && cyc < budget) begin
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (out_ch !== 3'(e.ch) || out_dat !== 10'(e.dat) || out_last !== e.last)
                    $display("FAIL %s sample: got ch=%0d dat=%0d last=%b, required ch=%0d dat=%0d last=%b",
                             tag, out_ch, out_dat, out_last, e.ch, e.dat, e.last);
                else begin
                    passed++;
                    $display("%s: ch=%0d dat=%0d last=%b", tag, out_ch, out_dat, out_last);
                end
                started = 1'b1;
            end else if (no_bubble && started) begin
                checks++;
                $display("FAIL %s bubble: out_valid=%b required 1 between samples", tag, out_valid);
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) $display("FAIL %s drain: %0d samples outstanding, required 0", tag, exp_q.size());
        else passed++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: %b required 0", out_valid); else passed++;
        checks++; if (out_dat !== 10'd0) $display("FAIL reset out_dat: %0d required 0", out_dat); else passed++;
        checks++; if (out_ch !== 3'd0) $display("FAIL reset out_ch: %0d required 0", out_ch); else passed++;
        checks++; if (out_last !== 1'b0) $display("FAIL reset out_last: %b required 0", out_last); else passed++;
        checks++; if (ovf !== 8'h00) $display("FAIL reset ovf: %h required 00", ovf); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset busy: %b required 0", busy); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        stage_word(3, 1, 1'b1, 1'b1);
        step_push();
        checks++; if (out_valid !== 1'b0) $display("FAIL latency k: out_valid=%b required 0", out_valid); else passed++;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("FAIL latency k+1: out_valid=%b required 0", out_valid); else passed++;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) $display("FAIL latency k+2: out_valid=%b required 1", out_valid); else passed++;
        drain(10, 1'b1, "single");
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL single idle: valid=%b busy=%b required 0 0", out_valid, busy); else passed++;
    endtask

    task automatic test_back_to_back();
        reset_dut();
        out_ready = 1'b1;
        stage_word(0, 100, 1'b0, 1'b1);
        stage_word(1, 200, 1'b1, 1'b1);
        stage_word(7, 300, 1'b0, 1'b1);
        step_push();
        wait_valid("b2b");
        drain(30, 1'b1, "b2b");
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b idle: out_valid=%b required 0", out_valid); else passed++;
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        stage_word(5, 50, 1'b0, 1'b0);
        step_push();
        wait_valid("stall");
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (out_dat !== 10'(50 + k) || out_ch !== 3'd5)
                $display("FAIL stall lane%0d: dat=%0d ch=%0d required %0d 5", k, out_dat, out_ch, 50 + k);
            else passed++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_dat !== 10'd52 || out_ch !== 3'd5)
                $display("FAIL stall hold%0d: valid=%b dat=%0d ch=%0d required 1 52 5", k, out_valid, out_dat, out_ch);
            else passed++;
        end
        out_ready = 1'b1;
        exp_q.push_back('{ch: 5, dat: 52, last: 1'b0});
        exp_q.push_back('{ch: 5, dat: 53, last: 1'b0});
        drain(10, 1'b1, "stall");
    endtask

    task automatic test_overflow();
        reset_dut();
        out_ready = 1'b0;
        stage_word(2, 0, 1'b0, 1'b1);
        step_push();
        wait_valid("ovf");
        for (int w = 1; w <= 16; w++) begin
            stage_word(2, w * 4, (w % 2) == 1, 1'b1);
            step_push();
        end
        checks++; if (ovf !== 8'h00) $display("FAIL ovf full: ovf=%h required 00", ovf); else passed++;
        stage_word(2, 68, 1'b0, 1'b0);
        step_push();
        checks++; if (ovf !== 8'h04) $display("FAIL ovf set: ovf=%h required 04", ovf); else passed++;
        stage_word(2, 72, 1'b0, 1'b0);
        ovf_clr = 1'b1;
        step_push();
        ovf_clr = 1'b0;
        checks++; if (ovf !== 8'h04) $display("FAIL ovf set_wins: ovf=%h required 04", ovf); else passed++;
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++; if (ovf !== 8'h00) $display("FAIL ovf clear: ovf=%h required 00", ovf); else passed++;
        out_ready = 1'b1;
        drain(100, 1'b1, "ovf");
    endtask

    task automatic test_reset_mid();
        int bad;
        out_ready = 1'b1;
        stage_word(4, 40, 1'b1, 1'b0);
        step_push();
        wait_valid("rstmid");
        stage_word(6, 60, 1'b0, 1'b0);
        checks++; if (out_dat !== 10'd40) $display("FAIL rstmid lane0: %0d required 40", out_dat); else passed++;
        step_push();
        checks++; if (out_dat !== 10'd41) $display("FAIL rstmid lane1: %0d required 41", out_dat); else passed++;
        @(negedge clk);
        checks++; if (out_dat !== 10'd42) $display("FAIL rstmid lane2: %0d required 42", out_dat); else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_dat !== 10'd0 || out_ch !== 3'd0 || out_last !== 1'b0 || busy !== 1'b0 || ovf !== 8'h00)
            $display("FAIL rstmid async: valid=%b dat=%0d ch=%0d last=%b busy=%b ovf=%h required all 0",
                     out_valid, out_dat, out_ch, out_last, busy, ovf);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) $display("FAIL rstmid quiet: %0d active cycles required 0", bad); else passed++;
    endtask

    task automatic test_random();
        int seq;
        int delivered;
        int c;
        int skipped;
        bit found;
        bit lb;
        logic [15:0] d;
        logic [1:0] ovf_seen;
        seq = 0;
        delivered = 0;
        ovf_seen = '0;
        for (int cyc = 0; cyc < 460; cyc++) begin
            ovf_seen = ovf_seen | s_ovf;
            if (s_valid && s_ready) begin
                c = int'(s_ch);
                found = 1'b0;
                skipped = 0;
                while (sq[c].size() > 0 && !found) begin
                    d = sq[c].pop_front();
                    if (d === s_dat) found = 1'b1;
                    else skipped++;
                end
                delivered++;
                checks++;
                if (!found || (skipped > 0 && !ovf_seen[c]) || s_last !== s_dat[0])
                    $display("FAIL rand sample: ch=%0d dat=%h last=%b found=%b skipped=%0d ovf_seen=%b",
                             c, s_dat, s_last, found, skipped, ovf_seen[c]);
                else begin
                    passed++;
                    $display("rand: ch=%0d dat=%h last=%b", c, s_dat, s_last);
                end
            end
            s_in_en = '0;
            s_in_last = '0;
            if (cyc < 400) begin
                for (int ch = 0; ch < 2; ch++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        lb = 1'($urandom_range(0, 1));
                        d = {1'(ch), 14'(seq), lb};
                        seq++;
                        s_in_en[ch] = 1'b1;
                        s_in_last[ch] = lb;
                        s_in_dat[ch*16 +: 16] = d;
                        sq[ch].push_back(d);
                    end
                end
                s_ready = ($urandom_range(0, 3) != 0);
            end else begin
                s_ready = 1'b1;
            end
            @(negedge clk);
        end
        for (int ch = 0; ch < 2; ch++) begin
            checks++;
            if (sq[ch].size() != 0 && !ovf_seen[ch])
                $display("FAIL rand loss ch%0d: %0d words undelivered with ovf=0", ch, sq[ch].size());
            else passed++;
        end
        checks++;
        if (delivered < 100) $display("FAIL rand volume: %0d samples delivered required >= 100", delivered);
        else passed++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
